// File: rtl/population_eval_scheduler_pkg.sv
// Shared types and constants for the population evaluation scheduler.
package population_eval_scheduler_pkg;

  localparam int NUM_OUT_BITS = 8;
  localparam int ERR_W        = 32;

  // Width that holds the sum of numSums values of sumW bits without wrapping.
  function automatic int fitWidth(input int numSums, input int sumW);
    return sumW + $clog2(numSums);
  endfunction

  localparam int FIT_W_DEFAULT = fitWidth(NUM_OUT_BITS, ERR_W);

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    WAIT_DONE,
    REDUCE,
    ACK,
    NEXT,
    ABORT_ACK
  } schedState_t;

endpackage

// File: rtl/population_eval_scheduler_reducer.sv
// Combinational reduction of the evaluator's per-output error sums into one
// fitness word, plus the strict-less compare against the current best.
module fitness_reducer
  import population_eval_scheduler_pkg::*;
#(
  parameter int FIT_W = FIT_W_DEFAULT
) (
  input  logic [NUM_OUT_BITS-1:0][ERR_W-1:0] iErrorSums,
  input  logic [FIT_W-1:0]                   iBestFitness,
  output logic [FIT_W-1:0]                   oFitness,
  output logic                               oIsBetter
);

  logic [FIT_W-1:0] level1 [4];
  logic [FIT_W-1:0] level2 [2];

  // Balanced three-level tree; every stage is already FIT_W wide so no carry is lost.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      level1[i] = FIT_W'(iErrorSums[2*i]) + FIT_W'(iErrorSums[2*i+1]);
    end
    for (int i = 0; i < 2; i++) begin
      level2[i] = level1[2*i] + level1[2*i+1];
    end
    oFitness = level2[0] + level2[1];
  end

  // Strict compare so that ties keep the earlier individual.
  assign oIsBetter = (oFitness < iBestFitness);

endmodule

// File: rtl/population_eval_scheduler.sv
// Walks one generation through the single chromosome evaluator and records
// per-individual fitness plus the best individual.
//
// state     | meaning
// IDLE      | no generation in progress
// FETCH     | population RAM address presented
// LOAD      | RAM data latched into the description register
// START     | start request held until the evaluator is ready
// WAIT_DONE | evaluator running
// REDUCE    | fitness written, best updated
// ACK       | done acknowledged until evaluator drops done
// NEXT      | advance index or finish the generation
// ABORT_ACK | abandoned evaluation: wait for done, then acknowledge it
module population_eval_scheduler
  import population_eval_scheduler_pkg::*;
#(
  parameter int POP_SIZE = 16,
  parameter int IDX_W    = 8,
  parameter int DESC_W   = 992,
  parameter int FIT_W    = FIT_W_DEFAULT
) (
  input  logic                               iClock,
  input  logic                               iReset_n,
  input  logic                               iStartGeneration,
  input  logic                               iAbort,
  output logic                               oBusy,
  output logic                               oGenerationDone,
  output logic [IDX_W-1:0]                   oPopAddr,
  input  logic [DESC_W-1:0]                  iPopData,
  output logic [DESC_W-1:0]                  oChromDescription,
  input  logic                               iEvalReady,
  output logic                               oEvalStart,
  input  logic                               iEvalDone,
  output logic                               oEvalDoneAck,
  input  logic [NUM_OUT_BITS-1:0][ERR_W-1:0] iErrorSums,
  output logic                               oFitWrEn,
  output logic [IDX_W-1:0]                   oFitAddr,
  output logic [FIT_W-1:0]                   oFitData,
  output logic [IDX_W-1:0]                   oBestIndex,
  output logic [FIT_W-1:0]                   oBestFitness
);

  schedState_t      state, stateNext;
  logic [IDX_W-1:0] index;
  logic             ackPhase;
  logic             abortPending;
  logic [FIT_W-1:0] fitness;
  logic             isBetter;
  logic             isLast;
  logic             stopAfterThis;

  fitness_reducer #(.FIT_W(FIT_W)) uReducer (
    .iErrorSums  (iErrorSums),
    .iBestFitness(oBestFitness),
    .oFitness    (fitness),
    .oIsBetter   (isBetter)
  );

  assign isLast        = (index == IDX_W'(POP_SIZE - 1));
  assign stopAfterThis = abortPending | iAbort;
  assign oBusy         = (state != IDLE);
  assign oPopAddr      = index;
  assign oFitAddr      = oFitWrEn ? index : '0;
  assign oFitData      = oFitWrEn ? fitness : '0;

  always_comb begin
    stateNext       = state;
    oEvalStart      = 1'b0;
    oEvalDoneAck    = 1'b0;
    oFitWrEn        = 1'b0;
    oGenerationDone = 1'b0;
    case (state)
      IDLE: begin
        if (iStartGeneration) stateNext = FETCH;
      end
      FETCH: begin
        stateNext = iAbort ? IDLE : LOAD;
      end
      LOAD: begin
        stateNext = iAbort ? IDLE : START;
      end
      START: begin
        // Start is withheld on abort so the evaluator never sees a request we abandon.
        if (iAbort) begin
          stateNext = IDLE;
        end else begin
          oEvalStart = 1'b1;
          if (iEvalReady) stateNext = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (iAbort)         stateNext = ABORT_ACK;
        else if (iEvalDone) stateNext = REDUCE;
      end
      REDUCE: begin
        if (iAbort) begin
          stateNext = ABORT_ACK;
        end else begin
          oFitWrEn  = 1'b1;
          stateNext = ACK;
        end
      end
      ACK: begin
        oEvalDoneAck = 1'b1;
        if (!iEvalDone) stateNext = NEXT;
      end
      NEXT: begin
        if (isLast || stopAfterThis) begin
          oGenerationDone = isLast && !stopAfterThis;
          stateNext       = IDLE;
        end else begin
          stateNext = FETCH;
        end
      end
      ABORT_ACK: begin
        if (ackPhase) begin
          oEvalDoneAck = 1'b1;
          if (!iEvalDone) stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state             <= IDLE;
      index             <= '0;
      oChromDescription <= '0;
      oBestIndex        <= '0;
      oBestFitness      <= '1;
      ackPhase          <= 1'b0;
      abortPending      <= 1'b0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (iStartGeneration) begin
            index        <= '0;
            oBestIndex   <= '0;
            oBestFitness <= '1;
            abortPending <= 1'b0;
          end
        end
        LOAD: oChromDescription <= iPopData;
        REDUCE: begin
          if (oFitWrEn && isBetter) begin
            oBestFitness <= fitness;
            oBestIndex   <= index;
          end
        end
        ACK: begin
          if (iAbort) abortPending <= 1'b1;
        end
        NEXT: begin
          abortPending <= 1'b0;
          if (stateNext == FETCH) index <= index + 1'b1;
        end
        default: ;
      endcase
      // ackPhase marks that done has been seen while abandoning an evaluation.
      if (state != ABORT_ACK)  ackPhase <= 1'b0;
      else if (iEvalDone)      ackPhase <= 1'b1;
    end
  end

endmodule

// File: tb/tb_population_eval_scheduler.sv
// Randomized bench for population_eval_scheduler with a behavioural evaluator,
// population RAM and a fitness/best-individual reference model.
module tb_population_eval_scheduler;
  import population_eval_scheduler_pkg::*;

  localparam int POP    = 4;
  localparam int IDX_W  = 8;
  localparam int DESC_W = 992;
  localparam int FIT_W  = FIT_W_DEFAULT;

  logic                               iClock = 1'b0;
  logic                               iReset_n;
  logic                               iStartGeneration;
  logic                               iAbort;
  logic                               oBusy;
  logic                               oGenerationDone;
  logic [IDX_W-1:0]                   oPopAddr;
  logic [DESC_W-1:0]                  iPopData;
  logic [DESC_W-1:0]                  oChromDescription;
  logic                               iEvalReady;
  logic                               oEvalStart;
  logic                               iEvalDone;
  logic                               oEvalDoneAck;
  logic [NUM_OUT_BITS-1:0][ERR_W-1:0] iErrorSums;
  logic                               oFitWrEn;
  logic [IDX_W-1:0]                   oFitAddr;
  logic [FIT_W-1:0]                   oFitData;
  logic [IDX_W-1:0]                   oBestIndex;
  logic [FIT_W-1:0]                   oBestFitness;

  population_eval_scheduler #(
    .POP_SIZE(POP), .IDX_W(IDX_W), .DESC_W(DESC_W), .FIT_W(FIT_W)
  ) dut (
    .iClock(iClock), .iReset_n(iReset_n),
    .iStartGeneration(iStartGeneration), .iAbort(iAbort),
    .oBusy(oBusy), .oGenerationDone(oGenerationDone),
    .oPopAddr(oPopAddr), .iPopData(iPopData),
    .oChromDescription(oChromDescription),
    .iEvalReady(iEvalReady), .oEvalStart(oEvalStart),
    .iEvalDone(iEvalDone), .oEvalDoneAck(oEvalDoneAck),
    .iErrorSums(iErrorSums),
    .oFitWrEn(oFitWrEn), .oFitAddr(oFitAddr), .oFitData(oFitData),
    .oBestIndex(oBestIndex), .oBestFitness(oBestFitness)
  );

  always #5 iClock = ~iClock;

  int checkCount = 0;
  int errorCount = 0;

  task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus tables and reference model state
  logic [DESC_W-1:0] popMem  [POP];
  logic [31:0]       sumsTab [POP][NUM_OUT_BITS];
  longint unsigned   expFit  [POP];
  int                expBestIdx;
  longint unsigned   expBestFit;

  int evLatency   = 10;
  int evDoneHold  = 1;
  int readyStall  = 0;
  int startsThisGen, writesThisGen, genDoneCount, ackRises;

  function automatic void buildModel();
    expBestIdx = 0;
    expBestFit = 64'h7_FFFF_FFFF;
    for (int i = 0; i < POP; i++) begin
      expFit[i] = 0;
      for (int k = 0; k < NUM_OUT_BITS; k++) expFit[i] += longint'(sumsTab[i][k]);
    end
    for (int i = 0; i < POP; i++) begin
      if (i == 0 || expFit[i] < expBestFit) begin
        expBestFit = expFit[i];
        expBestIdx = i;
      end
    end
  endfunction

  function automatic void fillPopulation();
    for (int i = 0; i < POP; i++) begin
      for (int w = 0; w < DESC_W / 32; w++) popMem[i][w*32 +: 32] = $urandom;
      popMem[i][7:0] = 8'(i);
    end
  endfunction

  function automatic void setFitness(input int idx, input logic [31:0] value);
    for (int k = 0; k < NUM_OUT_BITS; k++) sumsTab[idx][k] = '0;
    sumsTab[idx][3] = value;
  endfunction

  // Population RAM: data for the address seen one cycle earlier
  initial begin
    logic [IDX_W-1:0] prevAddr;
    prevAddr = '0;
    iPopData = '0;
    forever begin
      @(negedge iClock);
      iPopData = (prevAddr < POP) ? popMem[prevAddr] : '0;
      prevAddr = oPopAddr;
    end
  end

  // Evaluator model: start/ready handshake, latency, done held until acked
  initial begin
    bit lastStart, lastReady, lastAck, evBusy;
    int evCnt, doneCnt, evIdx;
    iEvalReady = 1'b1;
    iEvalDone  = 1'b0;
    iErrorSums = '0;
    lastStart = 0; lastReady = 0; lastAck = 0; evBusy = 0;
    evCnt = 0; doneCnt = 0; evIdx = 0;
    forever begin
      @(negedge iClock);
      if (!iReset_n) begin
        evBusy = 0; iEvalDone = 1'b0; iEvalReady = 1'b1; iErrorSums = '0;
        lastStart = 0; lastReady = 0; lastAck = 0;
        continue;
      end
      if (oEvalDoneAck) checkValue("ackWithDone", 64'(iEvalDone), 64'd1);
      if (oEvalDoneAck && !lastAck) ackRises++;
      lastAck = oEvalDoneAck;
      if (lastStart && !lastReady && !evBusy && !iAbort)
        checkValue("startHeld", 64'(oEvalStart), 64'd1);
      if (lastStart && lastReady) begin
        evIdx = int'(oChromDescription[7:0]);
        checkValue("startIdx", 64'(evIdx), 64'(startsThisGen));
        if (evIdx < POP) checkValue("desc", 64'(oChromDescription == popMem[evIdx]), 64'd1);
        else evIdx = 0;
        startsThisGen++;
        evBusy = 1; evCnt = evLatency;
      end
      if (evBusy) begin
        iEvalReady = 1'b0;
        if (!iEvalDone) begin
          if (evCnt > 0) evCnt--;
          else begin
            iEvalDone = 1'b1;
            for (int k = 0; k < NUM_OUT_BITS; k++) iErrorSums[k] = sumsTab[evIdx][k];
            doneCnt = 1;
          end
        end else if (oEvalDoneAck && doneCnt >= evDoneHold) begin
          iEvalDone = 1'b0; iErrorSums = '0; evBusy = 0;
        end else begin
          doneCnt++;
        end
      end
      if (!evBusy) begin
        if (oEvalStart && readyStall > 0) begin
          iEvalReady = 1'b0; readyStall--;
        end else begin
          iEvalReady = 1'b1;
        end
      end
      lastStart = oEvalStart;
      lastReady = iEvalReady;
    end
  end

  // Fitness write / generation-done monitor
  always @(negedge iClock) begin
    if (iReset_n) begin
      if (oFitWrEn) begin
        checkValue("fitAddr", 64'(oFitAddr), 64'(writesThisGen));
        if (oFitAddr < POP) checkValue("fitData", 64'(oFitData), expFit[oFitAddr]);
        writesThisGen++;
      end
      if (oGenerationDone) genDoneCount++;
    end
  end

  task automatic resetCounters();
    startsThisGen = 0; writesThisGen = 0; genDoneCount = 0; ackRises = 0;
  endtask

  task automatic pulseStart();
    @(negedge iClock); iStartGeneration = 1'b1;
    @(negedge iClock); iStartGeneration = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int cyc;
    cyc = 0;
    while (oBusy && cyc < 5000) begin @(negedge iClock); cyc++; end
    checkValue(tag, 64'(oBusy), 64'd0);
  endtask

  task automatic runGeneration(input bit extraStart);
    int cyc;
    bit didExtra;
    buildModel();
    resetCounters();
    pulseStart();
    cyc = 0; didExtra = 0;
    while (oBusy && cyc < 5000) begin
      @(negedge iClock);
      iStartGeneration = 1'b0;
      if (extraStart && !didExtra && startsThisGen == 2) begin
        iStartGeneration = 1'b1; didExtra = 1;
      end
      cyc++;
    end
    iStartGeneration = 1'b0;
    checkValue("genTimeout", 64'(oBusy), 64'd0);
    checkValue("writes", 64'(writesThisGen), 64'(POP));
    checkValue("genDone", 64'(genDoneCount), 64'd1);
    checkValue("starts", 64'(startsThisGen), 64'(POP));
    checkValue("bestIdx", 64'(oBestIndex), 64'(expBestIdx));
    checkValue("bestFit", 64'(oBestFitness), expBestFit);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkValue({tag, "_busy"},   64'(oBusy), 64'd0);
    checkValue({tag, "_gdone"},  64'(oGenerationDone), 64'd0);
    checkValue({tag, "_start"},  64'(oEvalStart), 64'd0);
    checkValue({tag, "_ack"},    64'(oEvalDoneAck), 64'd0);
    checkValue({tag, "_wr"},     64'(oFitWrEn), 64'd0);
    checkValue({tag, "_faddr"},  64'(oFitAddr), 64'd0);
    checkValue({tag, "_fdata"},  64'(oFitData), 64'd0);
    checkValue({tag, "_paddr"},  64'(oPopAddr), 64'd0);
    checkValue({tag, "_bidx"},   64'(oBestIndex), 64'd0);
    checkValue({tag, "_bfit"},   64'(oBestFitness), 64'h7_FFFF_FFFF);
    checkValue({tag, "_desc0"},  64'(oChromDescription == '0), 64'd1);
  endtask

  initial begin
    int cyc;
    iReset_n = 1'b0; iStartGeneration = 1'b0; iAbort = 1'b0;
    fillPopulation();
    for (int i = 0; i < POP; i++) setFitness(i, 0);
    repeat (3) @(negedge iClock);
    checkResetOutputs("rst");
    iReset_n = 1'b1;

    // Directed: small sums, zero, full-scale overflow width, small value
    for (int k = 0; k < NUM_OUT_BITS; k++) begin
      sumsTab[0][k] = '0; sumsTab[1][k] = '0; sumsTab[2][k] = 32'hFFFF_FFFF;
      sumsTab[3][k] = 32'(k + 1);
    end
    sumsTab[0][0] = 32'd1; sumsTab[0][7] = 32'd2;
    evLatency = 10; evDoneHold = 1; readyStall = 0;
    runGeneration(0);

    // Ties keep the earlier index
    setFitness(0, 5); setFitness(1, 5); setFitness(2, 7); setFitness(3, 5);
    runGeneration(0);

    // Backpressure on start and done held for several cycles
    fillPopulation();
    evLatency = 4; evDoneHold = 3; readyStall = 20;
    runGeneration(0);
    checkValue("stallUsed", 64'(readyStall), 64'd0);

    // Randomized generations; one also pulses start mid-generation
    for (int g = 0; g < 6; g++) begin
      fillPopulation();
      for (int i = 0; i < POP; i++)
        for (int k = 0; k < NUM_OUT_BITS; k++)
          sumsTab[i][k] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
      evLatency  = $urandom_range(0, 12);
      evDoneHold = $urandom_range(1, 4);
      readyStall = $urandom_range(0, 5);
      runGeneration(g == 2);
    end

    // Abort while the second chromosome is being evaluated
    fillPopulation();
    for (int i = 0; i < POP; i++) setFitness(i, 32'(10 + i));
    evLatency = 10; evDoneHold = 2; readyStall = 0;
    buildModel();
    resetCounters();
    pulseStart();
    cyc = 0;
    while (startsThisGen < 2 && cyc < 2000) begin @(negedge iClock); cyc++; end
    checkValue("abortReach", 64'(startsThisGen), 64'd2);
    @(negedge iClock); @(negedge iClock);
    iAbort = 1'b1;
    @(negedge iClock);
    iAbort = 1'b0;
    waitIdle("abortIdle");
    repeat (3) @(negedge iClock);
    checkValue("abortWrites", 64'(writesThisGen), 64'd1);
    checkValue("abortGenDone", 64'(genDoneCount), 64'd0);
    checkValue("abortAcks", 64'(ackRises), 64'd2);
    checkValue("abortEvalIdle", 64'(iEvalDone), 64'd0);

    // Asynchronous reset while a fitness write is in progress
    fillPopulation();
    for (int i = 0; i < POP; i++) setFitness(i, 32'($urandom_range(0, 50)));
    evLatency = 3; evDoneHold = 1;
    buildModel();
    resetCounters();
    pulseStart();
    cyc = 0;
    while (!oFitWrEn && cyc < 2000) begin @(negedge iClock); cyc++; end
    checkValue("reduceReach", 64'(oFitWrEn), 64'd1);
    #2 iReset_n = 1'b0;
    #1 checkResetOutputs("midRst");
    @(negedge iClock);
    @(negedge iClock);
    iReset_n = 1'b1;
    fillPopulation();
    for (int i = 0; i < POP; i++) setFitness(i, 32'($urandom_range(0, 50)));
    runGeneration(0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL globalTimeout: simulation did not complete");
    $fatal(1);
  end

endmodule
